// File: rtl/countdown_timer_parameterized.sv
// Loadable down-counter / timer with one-shot and periodic (auto-reload) modes.
//
// A load is accepted in IDLE (load_ready high). The timer then counts down from
// the loaded value while enable is high, raises a one-cycle underflow pulse on
// the enabled edge after count has reached zero, and either reloads (periodic)
// or returns to IDLE (one-shot). stop aborts a running count silently.
//
// Ports:
//   clk         clock, all logic on the rising edge
//   reset_n     synchronous active-low reset, already synchronized to clk
//   load_valid  load request; load_value and periodic qualified by it
//   load_ready  high in IDLE, when a load can be accepted
//   load_value  start count, also the reload value in periodic mode
//   periodic    1 = auto-reload, 0 = one-shot; sampled at load acceptance
//   enable      count advances only while high
//   stop        abort a running count (no underflow pulse)
//   count       current count value
//   running     high while in RUN
//   underflow   one-cycle pulse when the count expires
//   load_err    one-cycle pulse on a zero or clamped (out-of-range) load
module countdown_timer_parameterized #(
    parameter int unsigned MAX_VALUE = 64,
    parameter int unsigned WIDTH     = $clog2(MAX_VALUE + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             periodic,
    input  logic             enable,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             underflow,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VALUE);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             underflow_q, underflow_d;
    logic             load_err_q, load_err_d;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            count_q     <= '0;
            reload_q    <= '0;
            mode_q      <= 1'b0;
            underflow_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            reload_q    <= reload_d;
            mode_q      <= mode_d;
            underflow_q <= underflow_d;
            load_err_q  <= load_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        reload_d    = reload_q;
        mode_d      = mode_q;
        underflow_d = 1'b0;
        load_err_d  = 1'b0;

        case (state_q)
            StIdle: begin
                // stop and enable have no effect while idle
                if (load_valid) begin
                    if (load_value == '0) begin
                        load_err_d = 1'b1;
                    end else begin
                        state_d = StRun;
                        mode_d  = periodic;
                        if (load_value > MaxVal) begin
                            // Clamp and flag, but still start the timer
                            count_d    = MaxVal;
                            reload_d   = MaxVal;
                            load_err_d = 1'b1;
                        end else begin
                            count_d  = load_value;
                            reload_d = load_value;
                        end
                    end
                end
            end
            StRun: begin
                // load_valid is ignored here: load_ready is low
                if (stop) begin
                    count_d = '0;
                    state_d = StIdle;
                end else if (enable) begin
                    if (count_q != '0) begin
                        count_d = count_q - WIDTH'(1);
                    end else begin
                        // Zero is held for one enabled cycle before expiring
                        underflow_d = 1'b1;
                        if (mode_q) begin
                            count_d = reload_q;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs
    always_comb begin
        running    = (state_q == StRun);
        load_ready = (state_q == StIdle);
        count      = count_q;
        underflow  = underflow_q;
        load_err   = load_err_q;
    end

endmodule

// File: tb/tb_countdown_timer_parameterized.sv
module tb_countdown_timer_parameterized;

    localparam int unsigned W = 7;  // $clog2(64 + 1)

    logic         clk = 1'b0;
    logic         reset_n;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_value;
    logic         periodic;
    logic         enable;
    logic         stop;
    logic [W-1:0] count;
    logic         running;
    logic         underflow;
    logic         load_err;

    int checks   = 0;
    int failures = 0;

    countdown_timer_parameterized #(
        .MAX_VALUE(64)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_value(load_value),
        .periodic  (periodic),
        .enable    (enable),
        .stop      (stop),
        .count     (count),
        .running   (running),
        .underflow (underflow),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         rst_n;
        logic         lv;
        logic [W-1:0] val;
        logic         per;
        logic         en;
        logic         stp;
        logic [W-1:0] e_count;
        logic         e_run;
        logic         e_uf;
        logic         e_err;
        logic         e_rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst_n, logic lv, int val, logic per, logic en, logic stp,
                                int e_count, logic e_run, logic e_uf, logic e_err, logic e_rdy);
        vec_t v;
        v.rst_n   = rst_n;
        v.lv      = lv;
        v.val     = W'(val);
        v.per     = per;
        v.en      = en;
        v.stp     = stp;
        v.e_count = W'(e_count);
        v.e_run   = e_run;
        v.e_uf    = e_uf;
        v.e_err   = e_err;
        v.e_rdy   = e_rdy;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int e_count, input logic e_run,
                             input logic e_uf, input logic e_err, input logic e_rdy);
        check({tag, ".count"},      32'(count),      32'(e_count));
        check({tag, ".running"},    32'(running),    32'(e_run));
        check({tag, ".underflow"},  32'(underflow),  32'(e_uf));
        check({tag, ".load_err"},   32'(load_err),   32'(e_err));
        check({tag, ".load_ready"}, 32'(load_ready), 32'(e_rdy));
    endtask

    task automatic drive(input logic rst_n, input logic lv, input int val, input logic per,
                         input logic en, input logic stp);
        reset_n    = rst_n;
        load_valid = lv;
        load_value = W'(val);
        periodic   = per;
        enable     = en;
        stop       = stp;
    endtask

    // Advance one clock edge and sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // rst_n lv val per en stp | count run uf err rdy
        // Reset for two cycles
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0, 0, 0, 0, 1));
        // One-shot load 5: 5,4,3,2,1,0 then underflow on the 6th edge
        vecs.push_back(mk(1, 1,   5, 0, 1, 0,   5, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0,   0, 0, 1, 0,   4, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0,   0, 0, 1, 0,   3, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0,   0, 0, 1, 0,   2, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0,   0, 0, 1, 0,   1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0,   0, 0, 1, 0,   0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0,   0, 0, 1, 0,   0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0,   0, 0, 1, 0,   0, 0, 0, 0, 1));
        // Out-of-range load clamps to 64 and flags
        vecs.push_back(mk(1, 1, 100, 0, 1, 0,  64, 1, 0, 1, 0));
        vecs.push_back(mk(1, 0,   0, 0, 1, 0,  63, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0,   0, 0, 1, 1,   0, 0, 0, 0, 1));
        // Zero load rejected
        vecs.push_back(mk(1, 1,   0, 1, 1, 0,   0, 0, 0, 1, 1));
        // stop/enable ignored in IDLE
        vecs.push_back(mk(1, 0,   0, 0, 0, 1,   0, 0, 0, 0, 1));
        // Exact MAX_VALUE accepted without error
        vecs.push_back(mk(1, 1,  64, 0, 1, 0,  64, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0,   0, 0, 1, 1,   0, 0, 0, 0, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].lv, int'(vecs[i].val), vecs[i].per, vecs[i].en,
                  vecs[i].stp);
            tick();
            check_all($sformatf("vec%0d", i), int'(vecs[i].e_count), vecs[i].e_run,
                      vecs[i].e_uf, vecs[i].e_err, vecs[i].e_rdy);
        end

        // Periodic load 3: 3,2,1,0,3(uf),2,1,0,3(uf),2 then stop at 2
        begin
            int exp_cnt[9] = '{2, 1, 0, 3, 2, 1, 0, 3, 2};
            logic exp_uf[9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
            drive(1, 1, 3, 1, 1, 0);
            tick();
            check_all("per.load", 3, 1, 0, 0, 0);
            drive(1, 0, 0, 0, 1, 0);
            for (int k = 0; k < 9; k++) begin
                tick();
                check_all($sformatf("per.e%0d", k + 1), exp_cnt[k], 1, exp_uf[k], 0, 0);
            end
            drive(1, 0, 0, 0, 1, 1);
            tick();
            check_all("per.stop", 0, 0, 0, 0, 1);
            drive(1, 0, 0, 0, 1, 0);
            tick();
            check_all("per.idle", 0, 0, 0, 0, 1);
        end

        // Pause: load 4, hold at 2 for 3 cycles, underflow on edge 8
        drive(1, 1, 4, 0, 1, 0);
        tick();
        check_all("pause.load", 4, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 0);
        tick();
        check_all("pause.e1", 3, 1, 0, 0, 0);
        tick();
        check_all("pause.e2", 2, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            // Load attempt while paused must be ignored
            drive(1, (k == 1), 7, 1, 0, 0);
            tick();
            check_all($sformatf("pause.hold%0d", k), 2, 1, 0, 0, 0);
        end
        drive(1, 1, 9, 1, 1, 0);
        tick();
        check_all("pause.e6", 1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 0);
        tick();
        check_all("pause.e7", 0, 1, 0, 0, 0);
        tick();
        check_all("pause.e8", 0, 0, 1, 0, 1);

        // Reset mid-run in periodic mode, then load 1
        drive(1, 1, 3, 1, 1, 0);
        tick();
        check_all("rst.load", 3, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 0);
        tick();
        check_all("rst.e1", 2, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        tick();
        check_all("rst.reset", 0, 0, 0, 0, 1);
        drive(1, 1, 1, 0, 1, 0);
        tick();
        check_all("rst.load1", 1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 0);
        tick();
        check_all("rst.e1b", 0, 1, 0, 0, 0);
        tick();
        check_all("rst.e2b", 0, 0, 1, 0, 1);
        tick();
        check_all("rst.e3b", 0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/countdown_timer_parameterized.md
Name: countdown_timer_parameterized

Overview:
- Loadable down-counter/timer. The counterpart of the team's up-counter-with-overflow: counts down from a loaded value to zero and flags underflow.
- One-shot or periodic (auto-reload) operation, with an enable/pause input and an abort input.
- Used as a programmable delay and tick generator alongside the up-counters in the same clock domain.

Parameters:
- MAX_VALUE, 64, largest loadable count value (inclusive).
- WIDTH, $clog2(MAX_VALUE+1), width of count and load_value. Derived; do not override.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset, already synchronized to clk.
- load_valid  input  1  load request; load_value and periodic are valid while high.
- load_ready  output  1  high when a load can be accepted (state IDLE).
- load_value  input  WIDTH  start count; also the reload value in periodic mode.
- periodic  input  1  sampled at load acceptance: 1 = auto-reload, 0 = one-shot.
- enable  input  1  count advances only while high; low holds count (pause).
- stop  input  1  abort a running count.
- count  output  WIDTH  current count value.
- running  output  1  high while state RUN.
- underflow  output  1  one-cycle pulse when count expires.
- load_err  output  1  one-cycle pulse on an out-of-range or zero load.

Behaviour:
- Reset (reset_n=0 at an edge):
  - State IDLE; count=0, underflow=0, load_err=0, running=0.
  - Internal reload_reg=0, mode_reg=0; load_ready=1 after that edge.
  - Reset mid-RUN aborts with no underflow pulse.
- States IDLE and RUN. running = (state==RUN); load_ready = (state==IDLE); both are combinational from state.
- IDLE, load_valid=1 (handshake completes at this edge):
  - load_value == 0: rejected. load_err=1 for one cycle; count, mode and state unchanged.
  - 1 <= load_value <= MAX_VALUE: count <= load_value, reload_reg <= load_value, mode_reg <= periodic, state -> RUN.
  - load_value > MAX_VALUE: clamped. Same as above with value MAX_VALUE, plus load_err=1 for one cycle.
- IDLE, load_valid=0: all state held. stop and enable are ignored in IDLE.
- RUN, load_valid: ignored, since load_ready=0. No effect on count or reload_reg.
- RUN priority, highest first:
  1. stop=1: count <= 0, state -> IDLE, no underflow pulse.
  2. enable=0: count, state and underflow all held (underflow=0).
  3. enable=1 and count != 0: count <= count-1.
  4. enable=1 and count == 0: underflow <= 1. Then:
     - mode_reg=1: count <= reload_reg, state stays RUN.
     - mode_reg=0: count stays 0, state -> IDLE.
- underflow and load_err are registered, default 0 every cycle unless set as above.
- Latency:
  - A value N accepted at edge E0 expires after N+1 enabled cycles.
  - underflow is high in the cycle following the (N+1)-th enabled edge after E0.
  - Periodic mode: underflow period is reload_reg+1 enabled cycles.
- One-shot expiry:
  - running falls on the same edge that raises underflow, and load_ready rises then.
  - A new load is accepted from the next edge onward.
- Arithmetic: decrement is only performed when count != 0, so count never wraps below 0. Count is always <= MAX_VALUE.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles -> count=0, running=0, underflow=0, load_err=0, load_ready=1.
- One-shot: load 5, periodic=0, enable=1 -> count 5,4,3,2,1,0 on successive cycles. underflow=1 for exactly one cycle, on the 6th edge after acceptance; running=0 and load_ready=1 at that same edge; count stays 0.
- Periodic plus stop: load 3, periodic=1 -> count 3,2,1,0,3,2,... with an underflow pulse every 4 cycles. Assert stop at count=2 -> next edge count=0, running=0, no underflow.
- Pause: load 4, drop enable for 3 cycles at count=2 -> count holds 2, underflow arrives 3 cycles later than without the pause (8 edges after acceptance). load_valid pulsed during RUN -> count unaffected.
- Range (MAX_VALUE=64): load 100 -> count=64, load_err pulse, running=1. Load 0 in IDLE -> load_err pulse, running stays 0, count unchanged.
- Reset mid-run: reset_n=0 at count=2 in periodic mode -> after that edge count=0, running=0, no underflow. A subsequent load 1 -> underflow 2 edges after acceptance.
